// File: rtl/regbank_write_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// regbank_pkg
// Shared types and constants for the register-bank write arbiter slice.
//   SIZE_REG  : width of one register
//   ADDR_REG  : register address width
//   NUM_REGS  : number of registers in the bank (2^ADDR_REG)
//   wr_req_t  : one buffered write {addr, data}
//   req_id_t  : requester identity (ALU writeback / load-immediate unit)
// -----------------------------------------------------------------------------
package regbank_pkg;

  localparam int SIZE_REG = 16;
  localparam int ADDR_REG = 2;
  localparam int NUM_REGS = 1 << ADDR_REG;

  typedef struct packed {
    logic [ADDR_REG-1:0] addr;
    logic [SIZE_REG-1:0] data;
  } wr_req_t;

  typedef enum logic {
    REQ_ALU  = 1'b0,
    REQ_LOAD = 1'b1
  } req_id_t;

endpackage

// File: rtl/regbank_write_arbiter_if.sv
// -----------------------------------------------------------------------------
// regbank_write_arbiter_if
// Bundles the two writeback request channels, the bank write port and the
// status outputs of the write arbiter.
//   master : requesters / bank side (drives valids, addresses, data, wb_stall)
//   slave  : the arbiter (drives readies, bank write port, mask, status)
// -----------------------------------------------------------------------------
interface regbank_write_arbiter_if
  import regbank_pkg::*;
#(
  parameter int size_reg = SIZE_REG,
  parameter int addr_reg = ADDR_REG
);

  logic                     wr_valid_0;
  logic                     wr_valid_1;
  logic [addr_reg-1:0]      wr_addr_0;
  logic [addr_reg-1:0]      wr_addr_1;
  logic [size_reg-1:0]      wr_data_0;
  logic [size_reg-1:0]      wr_data_1;
  logic                     wr_ready_0;
  logic                     wr_ready_1;
  logic                     wb_stall;
  logic                     write_reg;
  logic [addr_reg-1:0]      addr_R;
  logic [size_reg-1:0]      write_data;
  logic [(1<<addr_reg)-1:0] pending_mask;
  logic                     fifo_empty;
  logic                     fifo_full;

  modport master (
    output wr_valid_0, wr_valid_1, wr_addr_0, wr_addr_1,
           wr_data_0, wr_data_1, wb_stall,
    input  wr_ready_0, wr_ready_1, write_reg, addr_R, write_data,
           pending_mask, fifo_empty, fifo_full
  );

  modport slave (
    input  wr_valid_0, wr_valid_1, wr_addr_0, wr_addr_1,
           wr_data_0, wr_data_1, wb_stall,
    output wr_ready_0, wr_ready_1, write_reg, addr_R, write_data,
           pending_mask, fifo_empty, fifo_full
  );

endinterface

// File: rtl/regbank_wr_fifo.sv
// -----------------------------------------------------------------------------
// regbank_wr_fifo
// Write buffer of wr_req_t entries between the arbiter and the bank port.
// Ports:
//   clock, reset            : clock, asynchronous active-low reset (flushes
//                             pointers, count and storage)
//   push, push_req          : enqueue one request (ignored when full)
//   pop                     : dequeue the head (ignored when empty)
//   head                    : entry at the read pointer
//   full, empty             : occupancy status
//   entry_vld, entry_addr   : per-slot valid flag and destination address,
//                             used to build the pending-register mask
// FIFO_DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module regbank_wr_fifo
  import regbank_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 push,
  input  wr_req_t                              push_req,
  input  logic                                 pop,
  output wr_req_t                              head,
  output logic                                 full,
  output logic                                 empty,
  output logic [FIFO_DEPTH-1:0]                entry_vld,
  output logic [FIFO_DEPTH-1:0][ADDR_REG-1:0]  entry_addr
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(FIFO_DEPTH);

  wr_req_t               mem [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] vld;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W:0]        count;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count == DEPTH_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Push and pop never address the same slot in one cycle: that would need
  // wr_ptr == rd_ptr, i.e. empty (no pop) or full (no push).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
        vld[i] <= 1'b0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_req;
        vld[wr_ptr] <= 1'b1;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        vld[rd_ptr] <= 1'b0;
        rd_ptr      <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    entry_vld = vld;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      entry_addr[i] = mem[i].addr;
    end
  end

endmodule

// File: rtl/regbank_write_arbiter.sv
// -----------------------------------------------------------------------------
// regbank_write_arbiter
// Shares the register bank's single write port between the ALU writeback
// (requester 0) and the load/immediate unit (requester 1). Accepted writes
// are buffered in regbank_wr_fifo and drained one per cycle unless wb_stall.
// Ports:
//   clock  : rising-edge clock
//   reset  : asynchronous active-low reset
//   bus    : regbank_write_arbiter_if.slave -- request channels, readies,
//            bank write port (write_reg/addr_R/write_data), pending_mask,
//            fifo_empty/fifo_full
// Configuration macro: REGBANK_ARB_FIXED_PRIO_EN
//   defined   -> requester 0 always wins ties (requester 1 may starve)
//   undefined -> round-robin on ties, tracked by last_grant
// -----------------------------------------------------------------------------
module regbank_write_arbiter
  import regbank_pkg::*;
#(
  parameter int size_reg   = SIZE_REG,
  parameter int addr_reg   = ADDR_REG,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  regbank_write_arbiter_if.slave bus
);

  localparam int NREG = 1 << addr_reg;

  req_id_t                              grant;
  logic                                 accept;
  wr_req_t                              push_req;
  wr_req_t                              head;
  logic                                 full;
  logic                                 empty;
  logic                                 pop;
  logic [FIFO_DEPTH-1:0]                entry_vld;
  logic [FIFO_DEPTH-1:0][ADDR_REG-1:0]  entry_addr;
  logic [addr_reg-1:0]                  head_addr;
  logic [size_reg-1:0]                  head_data;
  logic [NREG-1:0]                      mask;

`ifdef REGBANK_ARB_FIXED_PRIO_EN
  always_comb begin
    grant = (bus.wr_valid_1 && !bus.wr_valid_0) ? REQ_LOAD : REQ_ALU;
  end
`else
  req_id_t last_grant;

  // With neither or both valid, prefer whoever was not accepted last; this
  // also decides which ready is shown while idle.
  always_comb begin
    if (bus.wr_valid_0 && !bus.wr_valid_1)
      grant = REQ_ALU;
    else if (bus.wr_valid_1 && !bus.wr_valid_0)
      grant = REQ_LOAD;
    else
      grant = (last_grant == REQ_ALU) ? REQ_LOAD : REQ_ALU;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      last_grant <= REQ_LOAD;
    else if (accept)
      last_grant <= grant;
  end
`endif

  // Ready looks only at full, never at the pop, so a full FIFO blocks
  // acceptance even in the cycle it drains.
  assign bus.wr_ready_0 = reset && !full && (grant == REQ_ALU);
  assign bus.wr_ready_1 = reset && !full && (grant == REQ_LOAD);
  assign accept = (bus.wr_valid_0 && bus.wr_ready_0) ||
                  (bus.wr_valid_1 && bus.wr_ready_1);

  always_comb begin
    if (grant == REQ_ALU) begin
      push_req.addr = bus.wr_addr_0;
      push_req.data = bus.wr_data_0;
    end else begin
      push_req.addr = bus.wr_addr_1;
      push_req.data = bus.wr_data_1;
    end
  end

  regbank_wr_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (accept),
    .push_req   (push_req),
    .pop        (pop),
    .head       (head),
    .full       (full),
    .empty      (empty),
    .entry_vld  (entry_vld),
    .entry_addr (entry_addr)
  );

  assign pop           = !empty && !bus.wb_stall;
  assign head_addr     = empty ? '0 : head.addr;
  assign head_data     = empty ? '0 : head.data;
  assign bus.write_reg  = pop;
  assign bus.addr_R     = head_addr;
  assign bus.write_data = head_data;
  assign bus.fifo_empty = empty;
  assign bus.fifo_full  = full;

  always_comb begin
    mask = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (entry_vld[i])
        mask[entry_addr[i]] = 1'b1;
    end
  end

  assign bus.pending_mask = mask;

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regbank_write_arbiter
// Directed bench for regbank_write_arbiter: reset, single write, contention,
// stall/full, same-register ordering and asynchronous mid-operation reset.
// A small bank model records what the drain port commits.
// -----------------------------------------------------------------------------
module tb_regbank_write_arbiter;

  logic clock;
  logic reset;
  int   n_chk;
  int   n_fail;

  regbank_write_arbiter_if #(.size_reg(16), .addr_reg(2)) bus ();

  regbank_write_arbiter #(
    .size_reg   (16),
    .addr_reg   (2),
    .FIFO_DEPTH (2)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Bank model: written at the edge where write_reg is high, reset with the
  // arbiter.
  logic [15:0] bank [4];
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) bank[i] <= 16'h0;
    end else if (bus.write_reg) begin
      bank[bus.addr_R] <= bus.write_data;
    end
  end

  int acc_q[$];
  always @(posedge clock) begin
    if (bus.wr_valid_0 && bus.wr_ready_0) acc_q.push_back(0);
    if (bus.wr_valid_1 && bus.wr_ready_1) acc_q.push_back(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs;
    bus.wr_valid_0 = 1'b0;
    bus.wr_valid_1 = 1'b0;
    bus.wr_addr_0  = '0;
    bus.wr_addr_1  = '0;
    bus.wr_data_0  = '0;
    bus.wr_data_1  = '0;
  endtask

  int exp_acc [4];

  initial begin
    n_chk  = 0;
    n_fail = 0;
    reset  = 1'b0;
    idle_inputs();
    bus.wb_stall   = 1'b0;
    bus.wr_valid_0 = 1'b1;
    bus.wr_valid_1 = 1'b1;

    // Reset state with both requesters valid
    tick();
    check_eq("rst_ready0", bus.wr_ready_0, 0);
    check_eq("rst_ready1", bus.wr_ready_1, 0);
    check_eq("rst_write_reg", bus.write_reg, 0);
    check_eq("rst_mask", bus.pending_mask, 0);
    check_eq("rst_empty", bus.fifo_empty, 1);
    check_eq("rst_full", bus.fifo_full, 0);
    check_eq("rst_addr_R", bus.addr_R, 0);
    check_eq("rst_wdata", bus.write_data, 0);

    idle_inputs();
    tick();
    reset = 1'b1;
    #1;
    check_eq("rel_ready0", bus.wr_ready_0, 1);
    check_eq("rel_ready1", bus.wr_ready_1, 0);

    // Contention: both valid for four cycles
    acc_q.delete();
    bus.wr_valid_0 = 1'b1; bus.wr_addr_0 = 2'd1; bus.wr_data_0 = 16'h0011;
    bus.wr_valid_1 = 1'b1; bus.wr_addr_1 = 2'd3; bus.wr_data_1 = 16'h0033;
    repeat (4) tick();
    idle_inputs();
    tick();
`ifdef REGBANK_ARB_FIXED_PRIO_EN
    exp_acc = '{0, 0, 0, 0};
`else
    exp_acc = '{0, 1, 0, 1};
`endif
    check_eq("cont_count", acc_q.size(), 4);
    for (int i = 0; i < 4 && i < acc_q.size(); i++)
      check_eq($sformatf("cont_order%0d", i), acc_q[i], exp_acc[i]);
    check_eq("cont_empty", bus.fifo_empty, 1);
    check_eq("cont_bank1", bank[1], 16'h0011);
`ifdef REGBANK_ARB_FIXED_PRIO_EN
    check_eq("cont_bank3", bank[3], 16'h0000);
`else
    check_eq("cont_bank3", bank[3], 16'h0033);
`endif

    // Single write, one-cycle latency
    bus.wr_valid_0 = 1'b1; bus.wr_addr_0 = 2'd2; bus.wr_data_0 = 16'hA5A5;
    tick();
    idle_inputs();
    #1;
    check_eq("sw_write_reg", bus.write_reg, 1);
    check_eq("sw_addr_R", bus.addr_R, 2);
    check_eq("sw_wdata", bus.write_data, 16'hA5A5);
    check_eq("sw_mask", bus.pending_mask, 4'b0100);
    check_eq("sw_empty", bus.fifo_empty, 0);
    tick();
    check_eq("sw_empty_after", bus.fifo_empty, 1);
    check_eq("sw_mask_after", bus.pending_mask, 4'b0000);
    check_eq("sw_write_reg_after", bus.write_reg, 0);
    check_eq("sw_bank2", bank[2], 16'hA5A5);

    // Stall until full, then release
    bus.wb_stall = 1'b1;
    bus.wr_valid_0 = 1'b1; bus.wr_addr_0 = 2'd0; bus.wr_data_0 = 16'h1111;
    tick();
    idle_inputs();
    bus.wr_valid_1 = 1'b1; bus.wr_addr_1 = 2'd1; bus.wr_data_1 = 16'h2222;
    tick();
    idle_inputs();
    bus.wr_valid_0 = 1'b1; bus.wr_addr_0 = 2'd2; bus.wr_data_0 = 16'h3333;
    #1;
    check_eq("full_flag", bus.fifo_full, 1);
    check_eq("full_mask", bus.pending_mask, 4'b0011);
    check_eq("full_ready0", bus.wr_ready_0, 0);
    check_eq("full_ready1", bus.wr_ready_1, 0);
    check_eq("full_write_reg", bus.write_reg, 0);
    bus.wb_stall = 1'b0;
    #1;
    check_eq("rel_write_reg", bus.write_reg, 1);
    check_eq("rel_addr0", bus.addr_R, 0);
    check_eq("rel_data0", bus.write_data, 16'h1111);
    check_eq("rel_no_passthru", bus.wr_ready_0, 0);
    tick();
    check_eq("rec_ready0", bus.wr_ready_0, 1);
    check_eq("rec_addr1", bus.addr_R, 1);
    check_eq("rec_data1", bus.write_data, 16'h2222);
    tick();
    idle_inputs();
    #1;
    check_eq("rec_addr2", bus.addr_R, 2);
    check_eq("rec_data2", bus.write_data, 16'h3333);
    tick();
    check_eq("rec_empty", bus.fifo_empty, 1);
    check_eq("rec_bank0", bank[0], 16'h1111);
    check_eq("rec_bank1", bank[1], 16'h2222);
    check_eq("rec_bank2", bank[2], 16'h3333);

    // Same-register ordering
    bus.wb_stall = 1'b1;
    bus.wr_valid_0 = 1'b1; bus.wr_addr_0 = 2'd3; bus.wr_data_0 = 16'h0001;
    tick();
    idle_inputs();
    bus.wr_valid_1 = 1'b1; bus.wr_addr_1 = 2'd3; bus.wr_data_1 = 16'h0002;
    tick();
    idle_inputs();
    #1;
    check_eq("same_mask", bus.pending_mask, 4'b1000);
    check_eq("same_full", bus.fifo_full, 1);
    bus.wb_stall = 1'b0;
    #1;
    check_eq("same_first", bus.write_data, 16'h0001);
    tick();
    check_eq("same_second", bus.write_data, 16'h0002);
    check_eq("same_addr", bus.addr_R, 3);
    tick();
    check_eq("same_bank3", bank[3], 16'h0002);
    check_eq("same_empty", bus.fifo_empty, 1);

    // Asynchronous reset with a full FIFO
    bus.wb_stall = 1'b1;
    bus.wr_valid_0 = 1'b1; bus.wr_addr_0 = 2'd0; bus.wr_data_0 = 16'hDEAD;
    tick();
    idle_inputs();
    bus.wr_valid_1 = 1'b1; bus.wr_addr_1 = 2'd1; bus.wr_data_1 = 16'hBEEF;
    tick();
    idle_inputs();
    #1;
    check_eq("mr_full", bus.fifo_full, 1);
    bus.wb_stall = 1'b0;
    #1;
    check_eq("mr_write_reg_pre", bus.write_reg, 1);
    reset = 1'b0;
    #1;
    check_eq("mr_empty", bus.fifo_empty, 1);
    check_eq("mr_write_reg", bus.write_reg, 0);
    check_eq("mr_full_clr", bus.fifo_full, 0);
    check_eq("mr_mask", bus.pending_mask, 0);
    check_eq("mr_addr_R", bus.addr_R, 0);
    check_eq("mr_wdata", bus.write_data, 0);
    check_eq("mr_ready0", bus.wr_ready_0, 0);
    tick();
    reset = 1'b1;
    tick();
    tick();
    check_eq("mr_post_empty", bus.fifo_empty, 1);
    check_eq("mr_post_write_reg", bus.write_reg, 0);
    check_eq("mr_bank0", bank[0], 16'h0000);
    check_eq("mr_bank1", bank[1], 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/regbank_write_arbiter.md
# regbank_write_arbiter

Shares the single write port of the 4-entry, 16-bit register bank between two writeback sources: requester 0 is the ALU writeback and requester 1 is the load/immediate unit. Accepted writes are buffered in a small FIFO and drained one per cycle into the bank's `write_reg`/`addr_R`/`write_data` inputs. The block also exports a per-register pending mask so the issue logic can stall reads of registers with writes still in flight.

## Interface
Parameters:
- `size_reg`, 16, data width of one register
- `addr_reg`, 2, register address width; the bank has 2^addr_reg registers
- `FIFO_DEPTH`, 2, number of write-buffer entries; must be a power of two, ≥2

Ports:
- `clock`  in  1  single clock; all state updates on its rising edge
- `reset`  in  1  asynchronous, active-low reset
- `wr_valid_0`, `wr_valid_1`  in  1  requester has a write pending
- `wr_addr_0`, `wr_addr_1`  in  addr_reg  destination register
- `wr_data_0`, `wr_data_1`  in  size_reg  write data
- `wr_ready_0`, `wr_ready_1`  out  1  write accepted this cycle when valid && ready
- `wb_stall`  in  1  holds the bank write port; no drain this cycle
- `write_reg`  out  1  to the bank's write enable
- `addr_R`  out  addr_reg  to the bank's write address
- `write_data`  out  size_reg  to the bank's write data
- `pending_mask`  out  2^addr_reg  bit k = 1 while any FIFO entry targets register k
- `fifo_empty`, `fifo_full`  out  1  status

## Operation
Arbitration:
- If only one `wr_valid_i` is high, that requester is granted.
- If both are high, the requester not accepted most recently is granted (round-robin).
- `last_grant` updates only on an accept. Its reset value makes requester 0 win the first tie.
- `wr_ready_i = reset && !fifo_full && grant==i`. Only one ready is high per cycle.
- Ready depends combinationally on the valids, but never on `wb_stall` or on a same-cycle pop.

Accept and push:
- On valid && ready, `{addr, data}` is pushed at the clock edge.
- A requester must hold valid, addr and data stable until accepted.

Drain:
- `write_reg = !fifo_empty && !wb_stall`.
- `addr_R` and `write_data` show the FIFO head, or zero when empty.
- The pop happens at the edge where `write_reg` = 1. The bank writes at that same edge.

FIFO:
- Read and write pointers are addr-wrapped, with an occupancy counter of width $clog2(FIFO_DEPTH)+1.
- Push and pop may occur in the same cycle when the FIFO is non-full and non-empty; the count is unchanged.
- Pointers wrap from FIFO_DEPTH-1 to 0.

Ordering:
- Writes commit in acceptance order, so two writes to the same register resolve last-accepted-wins.

pending_mask:
- OR of one-hot decodes of the addresses of all valid FIFO entries.
- Computed combinationally from storage.

Reset (reset low, asynchronous):
- The FIFO is flushed: pointers and count go to 0 and entry storage is cleared.
- `last_grant` is set to 1, so requester 0 has priority.
- Outputs: `write_reg`=0, `addr_R`=0, `write_data`=0, `pending_mask`=0, `fifo_empty`=1, `fifo_full`=0, both `wr_ready`=0.
- A reset mid-operation discards buffered writes; the bank itself is reset by the same signal.

## Timing
- Accept at edge T with an empty FIFO and no stall: `write_reg`=1 during cycle T..T+1, and the bank is updated at edge T+1. Write latency is 1 cycle.
- `pending_mask` bit is set from edge T until edge T+1, when the pop occurs.
- Throughput is one write per cycle when `wb_stall` is low. The full FIFO only occurs under stall.
- Full: ready is 0 in the cycle full is seen, even if a pop occurs that cycle. There is no pass-through.
- Recovery from full: one-cycle bubble after the stall releases.

## Configuration
- Macro `REGBANK_ARB_FIXED_PRIO_EN`.
- When defined: requester 0 always wins ties, `last_grant` is not implemented, and requester 1 can starve.
- When undefined: round-robin as described under Operation.

## Structure
- Package `regbank_pkg`:
  - `SIZE_REG`, `ADDR_REG`, `NUM_REGS` constants
  - `typedef struct packed {logic [ADDR_REG-1:0] addr; logic [SIZE_REG-1:0] data;} wr_req_t`
  - `typedef enum logic {REQ_ALU, REQ_LOAD} req_id_t`
- One sub-module `regbank_wr_fifo`: parameterised FIFO of `wr_req_t` with push, pop, full, empty, head and an entry-address vector for the pending mask.
- The arbiter and mask logic are in the top level.

## Test plan
- **Reset:** reset low with both valid → both ready 0, `write_reg`=0, `pending_mask`=0000; release → `wr_ready_0`=1.
- **Single write:** `wr_valid_0`=1, addr=2, data=16'hA5A5 for one cycle → next cycle `write_reg`=1, `addr_R`=2, `write_data`=A5A5, `pending_mask`=0100; one cycle later empty, mask=0000.
- **Contention, round-robin:** both valid for 4 cycles (r0 addr=1, r1 addr=3) → acceptance order 0,1,0,1. With `REGBANK_ARB_FIXED_PRIO_EN` → 0,0,0,0.
- **Stall and full:** `wb_stall`=1, push writes to reg 0 then reg 1 → `fifo_full`=1, mask=0011, ready 0. Release stall → writes reg 0 then reg 1 on consecutive cycles, then ready returns.
- **Same-register ordering:** r0 writes reg 3 = 0x0001, then r1 writes reg 3 = 0x0002 under stall → drained in that order; the bank holds 0x0002.
- **Mid-operation reset:** FIFO full, assert reset → `fifo_empty`=1 and `write_reg`=0 immediately (asynchronously); no buffered write reaches the bank.
